// File: rtl/layer_fetch_sequencer.sv
// Operand fetch sequencer for one neural-network layer: walks every (neuron, input) pair,
// pulses ack per consumed pair and clears the layer counter/MAC between neurons.
module layer_fetch_sequencer #(
  parameter int unsigned NUM_INPUTS  = 3,
  parameter int unsigned NUM_NEURONS = 2,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned NEURON_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mem_ready,
  input  logic                ack__mac,
  output logic                ack,
  output logic [ADDR_W-1:0]   addr_x,
  output logic [ADDR_W-1:0]   addr_w,
  output logic [NEURON_W-1:0] neuron,
  output logic                mac_clr,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    NEXT,
    FINISH
  } state_e;

  localparam logic [ADDR_W-1:0]   LAST_I     = ADDR_W'(NUM_INPUTS - 1);
  localparam logic [ADDR_W-1:0]   STRIDE     = ADDR_W'(NUM_INPUTS);
  localparam logic [ADDR_W-1:0]   ADDR_ONE   = ADDR_W'(1);
  localparam logic [NEURON_W-1:0] LAST_N     = NEURON_W'(NUM_NEURONS - 1);
  localparam logic [NEURON_W-1:0] NEURON_ONE = NEURON_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_x_q, addr_x_d;
  logic [ADDR_W-1:0]   addr_w_q, addr_w_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [NEURON_W-1:0] neuron_q, neuron_d;
  logic                ack_q, ack_d;
  logic                mac_clr_q, mac_clr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    addr_x_d  = addr_x_q;
    addr_w_d  = addr_w_q;
    base_d    = base_q;
    neuron_d  = neuron_q;
    ack_d     = 1'b0;
    mac_clr_d = 1'b0;
    done_d    = 1'b0;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = FETCH;
          addr_x_d = '0;
          addr_w_d = '0;
          base_d   = '0;
          neuron_d = '0;
        end
      end
      FETCH: begin
        // The counter cannot legitimately be complete before the last pair was fetched.
        if (ack__mac) err_d = 1'b1;
        if (mem_ready) begin
          ack_d = 1'b1;
          if (addr_x_q == LAST_I) begin
            state_d = DRAIN;
          end else begin
            addr_x_d = addr_x_q + ADDR_ONE;
            addr_w_d = addr_w_q + ADDR_ONE;
          end
        end
      end
      DRAIN: begin
        if (ack__mac) state_d = (neuron_q == LAST_N) ? FINISH : NEXT;
      end
      NEXT: begin
        mac_clr_d = 1'b1;
        neuron_d  = neuron_q + NEURON_ONE;
        addr_x_d  = '0;
        addr_w_d  = base_q + STRIDE;
        base_d    = base_q + STRIDE;
        state_d   = FETCH;
      end
      FINISH: begin
        mac_clr_d = 1'b1;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State moves on the falling edge so it lines up with the layer counter.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_x_q  <= '0;
      addr_w_q  <= '0;
      base_q    <= '0;
      neuron_q  <= '0;
      ack_q     <= 1'b0;
      mac_clr_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register load from pre-edge values,
      // independent of statement order.
      state_q   <= state_d;
      addr_x_q  <= addr_x_d;
      addr_w_q  <= addr_w_d;
      base_q    <= base_d;
      neuron_q  <= neuron_d;
      ack_q     <= ack_d;
      mac_clr_q <= mac_clr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ack     = ack_q;
  assign addr_x  = addr_x_q;
  assign addr_w  = addr_w_q;
  assign neuron  = neuron_q;
  assign mac_clr = mac_clr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_layer_fetch_sequencer.sv
// Scoreboard bench for layer_fetch_sequencer: stimulus queues expected ack/clear/done
// events, a monitor pops and compares them whenever the DUT pulses an output.
module tb_layer_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, mem_ready = 1'b0, ack_mac = 1'b0;
  logic       ack, mac_clr, busy, done, err;
  logic [3:0] addr_x, addr_w;
  logic [1:0] neuron;

  logic       start2 = 1'b0, mem_ready2 = 1'b0, ack_mac2 = 1'b0;
  logic       ack2, mac_clr2, busy2, done2, err2;
  logic [1:0] addr_x2, addr_w2;
  logic       neuron2;

  int checks = 0;
  int errors = 0;
  int ack_total = 0;
  int clr_total = 0;

  typedef struct {
    logic [2:0] flags;  // {ack, mac_clr, done}
    logic [9:0] addr;   // {neuron, addr_w, addr_x}
  } exp_t;

  exp_t exp_q[$];

  layer_fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .mem_ready(mem_ready), .ack__mac(ack_mac),
    .ack(ack), .addr_x(addr_x), .addr_w(addr_w), .neuron(neuron),
    .mac_clr(mac_clr), .busy(busy), .done(done), .err(err)
  );

  layer_fetch_sequencer #(.NUM_INPUTS(1), .NUM_NEURONS(1), .ADDR_W(2), .NEURON_W(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mem_ready(mem_ready2), .ack__mac(ack_mac2),
    .ack(ack2), .addr_x(addr_x2), .addr_w(addr_w2), .neuron(neuron2),
    .mac_clr(mac_clr2), .busy(busy2), .done(done2), .err(err2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_ack(input logic [1:0] n, input logic [3:0] aw, input logic [3:0] ax);
    exp_q.push_back('{flags: 3'b100, addr: {n, aw, ax}});
  endfunction

  function automatic void push_clr(input logic [1:0] n, input logic [3:0] aw);
    exp_q.push_back('{flags: 3'b010, addr: {n, aw, 4'd0}});
  endfunction

  function automatic void push_done();
    exp_q.push_back('{flags: 3'b011, addr: 10'd0});
  endfunction

  // Monitor: an ack reports the pair that was on the address bus in the previous cycle.
  initial begin : monitor
    logic [9:0] prev_addr;
    exp_t       e;
    prev_addr = '0;
    forever begin
      @(posedge clk);
      if (!rst && (ack || mac_clr || done)) begin
        if (ack) ack_total++;
        if (mac_clr) clr_total++;
        if (exp_q.size() == 0) begin
          check("unexpected_event", 32'({ack, mac_clr, done}), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("event_flags", 32'({ack, mac_clr, done}), 32'(e.flags));
          if (e.flags == 3'b100) check("ack_pair", 32'(prev_addr), 32'(e.addr));
          if (e.flags == 3'b010) check("clr_addr", 32'({neuron, addr_w, addr_x}), 32'(e.addr));
        end
      end
      prev_addr = {neuron, addr_w, addr_x};
    end
  end

  task automatic wait_acks(input int n, input int budget);
    int cnt = 0;
    for (int k = 0; k < budget && cnt < n; k++) begin
      @(posedge clk);
      if (ack) cnt++;
    end
    check("ack_wait", cnt, n);
  endtask

  task automatic wait_clr(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      if (mac_clr) break;
    end
    check("clr_wait", 32'(mac_clr), 32'd1);
  endtask

  // Return the counter completion one cycle after the last ack, drop it on the clear.
  task automatic complete_neuron();
    @(posedge clk);
    ack_mac = 1'b1;
    wait_clr(30);
    ack_mac = 1'b0;
  endtask

  initial begin : stimulus
    int ones;
    int bad;
    int acks2;
    logic seen_done2;
    logic [5:0] pat;

    // Reset state.
    repeat (3) @(posedge clk);
    check("reset_outputs", 32'({ack, mac_clr, busy, done, err, addr_x, addr_w, neuron}), 32'd0);
    rst = 1'b0;

    // Full layer with mem_ready held high.
    push_ack(0, 0, 0); push_ack(0, 1, 1); push_ack(0, 2, 2); push_clr(1, 3);
    push_ack(1, 3, 0); push_ack(1, 4, 1); push_ack(1, 5, 2); push_done();
    mem_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    wait_acks(3, 20);
    complete_neuron();
    check("next_neuron", 32'({neuron, addr_w}), 32'({2'd1, 4'd3}));
    wait_acks(3, 20);
    complete_neuron();
    check("done_pulse", 32'({done, busy}), 32'b10);
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    check("done_one_cycle", 32'({done, mac_clr, busy}), 32'd0);
    check("layer_ack_count", ack_total, 6);
    check("layer_clr_count", clr_total, 2);

    // Stalled fetch, then a long DRAIN wait, then reset mid-FETCH of neuron 1.
    push_ack(0, 0, 0); push_ack(0, 1, 1); push_ack(0, 2, 2); push_clr(1, 3); push_ack(1, 3, 0);
    start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    pat  = 6'b101001;  // applied LSB first: 1,0,0,1,0,1
    ones = 0;
    for (int k = 0; k < 6; k++) begin
      mem_ready = pat[k];
      @(posedge clk);
      ones += int'(pat[k]);
      check("stall_ack", 32'(ack), 32'(pat[k]));
      check("stall_addr_x", 32'(addr_x), (ones >= 3) ? 32'd2 : 32'(ones));
    end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      if (ack || mac_clr || !busy) bad++;
    end
    check("drain_quiet", bad, 0);
    check("drain_addr_hold", 32'({neuron, addr_w, addr_x}), 32'({2'd0, 4'd2, 4'd2}));
    ack_mac = 1'b1;
    wait_clr(10);
    ack_mac = 1'b0;
    check("release_next", 32'({neuron, addr_w}), 32'({2'd1, 4'd3}));
    mem_ready = 1'b1;
    @(posedge clk);
    mem_ready = 1'b0;
    check("mid_fetch_addr_w", 32'(addr_w), 32'd4);
    #2 rst = 1'b1;
    #1;
    check("async_reset", 32'({ack, mac_clr, busy, done, err, addr_x, addr_w, neuron}), 32'd0);
    check("queue_drained_rst", exp_q.size(), 0);
    @(posedge clk);
    rst = 1'b0;

    // Restart from zero, start re-asserted in FETCH, early ack__mac raises err.
    push_ack(0, 0, 0); push_ack(0, 1, 1); push_ack(0, 2, 2); push_clr(1, 3);
    push_ack(1, 3, 0); push_ack(1, 4, 1); push_ack(1, 5, 2); push_done();
    start = 1'b1;
    @(posedge clk);
    check("restart_addr", 32'({busy, addr_w, addr_x}), 32'({1'b1, 8'd0}));
    start = 1'b0;
    ack_mac = 1'b1;
    @(posedge clk);
    check("early_mac_err", 32'({err, addr_x, ack}), 32'({1'b1, 4'd0, 1'b0}));
    start = 1'b1;
    ack_mac = 1'b0;
    @(posedge clk);
    start = 1'b0;
    mem_ready = 1'b1;
    wait_acks(3, 20);
    complete_neuron();
    wait_acks(3, 20);
    complete_neuron();
    check("err_sticky_done", 32'({done, err}), 32'b11);
    mem_ready = 1'b0;
    @(posedge clk);
    check("err_holds_idle", 32'({busy, err}), 32'b01);
    rst = 1'b1;
    #1;
    check("err_cleared", 32'(err), 32'd0);
    @(posedge clk);
    rst = 1'b0;

    // Single-input single-neuron layer: mac_clr and done coincide.
    acks2 = 0;
    seen_done2 = 1'b0;
    start2 = 1'b1;
    mem_ready2 = 1'b1;
    @(posedge clk);
    start2 = 1'b0;
    check("small_busy", 32'(busy2), 32'd1);
    for (int k = 0; k < 10 && !seen_done2; k++) begin
      @(posedge clk);
      if (ack2) begin
        acks2++;
        check("small_ack_addr", 32'({neuron2, addr_w2, addr_x2}), 32'd0);
        ack_mac2 = 1'b1;
      end
      if (done2) begin
        seen_done2 = 1'b1;
        check("small_done_clr", 32'({mac_clr2, busy2}), 32'b10);
      end
    end
    check("small_done_seen", 32'(seen_done2), 32'd1);
    check("small_ack_count", acks2, 1);
    ack_mac2 = 1'b0;
    mem_ready2 = 1'b0;
    @(posedge clk);
    check("small_idle", 32'({done2, mac_clr2, busy2, err2}), 32'd0);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
